// File: rtl/mem_fill_pkg.sv
// Shared types and constants for the memory fill writer.
package mem_fill_pkg;

  localparam int ADDR_WIDTH_DEF = 4;
  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_t;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/mem_fill_ram.sv
// DEPTH x DATA_WIDTH RAM: one synchronous write port, one registered read
// port (read-before-write on same-address collision), cleared on reset.
module mem_fill_ram
  import mem_fill_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = depth_of(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage array: cleared on reset, otherwise written on we.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Free-running registered read; sees the pre-write contents on a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/mem_fill_writer.sv
// Fills a RAM at addresses 0..DEPTH-1 from a valid/ready byte stream and
// exposes the contents through a registered read port.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | after reset; waiting for start, no writes accepted
// ST_FILL | wr_ready high; each transfer writes mem[ptr] and advances
// ST_DONE | all DEPTH words written; done high until start or rst
module mem_fill_writer
  import mem_fill_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  done,
  input  logic [ADDR_WIDTH-1:0] rd_address,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = depth_of(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  fill_state_t           state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  xfer;

  // Ready comes straight from the state so a transfer needs no extra cycle.
  assign wr_ready = (state == ST_FILL);
  assign xfer     = wr_valid & wr_ready;

  // Fill sequencer: state, write pointer, word count and done flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      wr_count <= '0;
      done     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_FILL;
            ptr      <= '0;
            wr_count <= '0;
          end
        end
        ST_FILL: begin
          if (xfer) begin
            ptr      <= ptr + ADDR_WIDTH'(1);
            wr_count <= wr_count + (ADDR_WIDTH + 1)'(1);
            if (ptr == LAST_ADDR) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (start) begin
            state    <= ST_FILL;
            ptr      <= '0;
            wr_count <= '0;
            done     <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          ptr      <= '0;
          wr_count <= '0;
          done     <= 1'b0;
        end
      endcase
    end
  end

  mem_fill_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (xfer),
    .waddr (ptr),
    .wdata (wr_data),
    .raddr (rd_address),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_mem_fill_writer.sv
// Directed bench for mem_fill_writer.
module tb_mem_fill_writer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic [4:0] wr_count;
  logic       done;
  logic [3:0] rd_address;
  logic [7:0] rd_data;

  int n_tests;
  int n_fail;

  mem_fill_writer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .wr_count   (wr_count),
    .done       (done),
    .rd_address (rd_address),
    .rd_data    (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input string tag, input logic [3:0] addr, input logic [7:0] exp);
    rd_address = addr;
    tick();
    chk(tag, {24'h0, rd_data}, {24'h0, exp});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
    wr_data  = 8'h00;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    start      = 1'b0;
    wr_valid   = 1'b0;
    wr_data    = 8'h00;
    rd_address = 4'h0;

    // Reset for two cycles.
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", {31'h0, wr_ready}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_count", {27'h0, wr_count}, 32'h0);
    chk("rst_rdata", {24'h0, rd_data}, 32'h0);
    for (int a = 0; a < 16; a++) read_chk("rst_mem", 4'(a), 8'h00);

    // Full fill with back-to-back transfers.
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      chk("fill_ready", {31'h0, wr_ready}, 32'h1);
      chk("fill_count", {27'h0, wr_count}, 32'(i));
      chk("fill_done_lo", {31'h0, done}, 32'h0);
      wr_valid = 1'b1;
      wr_data  = 8'hA0 + 8'(i);
      tick();
    end
    wr_valid = 1'b0;
    chk("full_done", {31'h0, done}, 32'h1);
    chk("full_count", {27'h0, wr_count}, 32'd16);
    chk("full_ready_lo", {31'h0, wr_ready}, 32'h0);
    for (int a = 0; a < 16; a++) read_chk("full_mem", 4'(a), 8'hA0 + 8'(a));

    // Backpressure: clear memory, then fill with wr_valid toggling.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pulse_start();
    for (int i = 0; i < 32; i++) begin
      wr_valid = (i % 2 == 0);
      wr_data  = (i % 2 == 0) ? 8'hA0 + 8'(i / 2) : 8'hEE;
      tick();
      if (i < 31) chk("gap_count", {27'h0, wr_count}, 32'(i / 2 + 1));
    end
    wr_valid = 1'b0;
    chk("gap_done", {31'h0, done}, 32'h1);
    chk("gap_count_end", {27'h0, wr_count}, 32'd16);
    for (int a = 0; a < 16; a++) read_chk("gap_mem", 4'(a), 8'hA0 + 8'(a));

    // Overrun in DONE is ignored.
    wr_valid = 1'b1;
    wr_data  = 8'hFF;
    tick();
    tick();
    tick();
    wr_valid = 1'b0;
    chk("ovr_count", {27'h0, wr_count}, 32'd16);
    chk("ovr_done", {31'h0, done}, 32'h1);
    read_chk("ovr_addr0", 4'h0, 8'hA0);
    read_chk("ovr_addr15", 4'hF, 8'hAF);

    // Re-arm with wr_valid in the start cycle: that byte must not land.
    start    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'h22;
    tick();
    start    = 1'b0;
    wr_valid = 1'b0;
    chk("rearm_done", {31'h0, done}, 32'h0);
    chk("rearm_count", {27'h0, wr_count}, 32'h0);
    chk("rearm_ready", {31'h0, wr_ready}, 32'h1);
    write_byte(8'h11);
    chk("rearm_count1", {27'h0, wr_count}, 32'h1);
    chk("rearm_done1", {31'h0, done}, 32'h0);
    // start while filling must not restart the fill.
    pulse_start();
    chk("fill_start_ign", {27'h0, wr_count}, 32'h1);
    read_chk("rearm_addr0", 4'h0, 8'h11);
    for (int a = 1; a < 16; a++) read_chk("rearm_mem", 4'(a), 8'hA0 + 8'(a));

    // Reset mid-fill after five writes total.
    write_byte(8'h12);
    write_byte(8'h13);
    write_byte(8'h14);
    write_byte(8'h15);
    chk("mid_count5", {27'h0, wr_count}, 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_count", {27'h0, wr_count}, 32'h0);
    chk("mid_ready", {31'h0, wr_ready}, 32'h0);
    chk("mid_done", {31'h0, done}, 32'h0);
    for (int a = 0; a < 16; a++) read_chk("mid_mem", 4'(a), 8'h00);

    // Refill from address 0, then collide read and write at address 3.
    pulse_start();
    write_byte(8'h01);
    write_byte(8'h02);
    write_byte(8'h03);
    rd_address = 4'h3;
    wr_valid   = 1'b1;
    wr_data    = 8'h55;
    tick();
    wr_valid = 1'b0;
    chk("coll_old", {24'h0, rd_data}, 32'h00);
    tick();
    chk("coll_new", {24'h0, rd_data}, 32'h55);
    chk("coll_count", {27'h0, wr_count}, 32'd4);
    read_chk("refill_addr0", 4'h0, 8'h01);
    read_chk("refill_addr2", 4'h2, 8'h03);
    read_chk("refill_addr4", 4'h4, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
